// File: rtl/bin2bcd_seq_if.sv
// rtl/bin2bcd_seq_if.sv - request/result bundle between the ALU side and the BCD converter
interface bin2bcd_seq_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  localparam int LD_W = $clog2(DIGITS + 1);

  logic                  start;
  logic                  signed_mode;
  logic [WIDTH-1:0]      A;
  logic                  busy;
  logic                  done;
  logic                  valid;
  logic [4*DIGITS-1:0]   bcd;
  logic                  sign;
  logic [LD_W-1:0]       lead_digits;
  logic                  overflow;

  // Requester side: issues operands, observes the result
  modport master (
    output start, signed_mode, A,
    input  busy, done, valid, bcd, sign, lead_digits, overflow
  );

  // Converter side
  modport slave (
    input  start, signed_mode, A,
    output busy, done, valid, bcd, sign, lead_digits, overflow
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-and-add-3 binary to BCD converter, signed input, overflow and digit count
module bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic         clk,
  input  logic         reset,
  bin2bcd_seq_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int LD_W  = $clog2(DIGITS + 1);
  localparam int BW    = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;

  // Operands captured with start so A may change afterwards
  logic [WIDTH-1:0]  a_q;
  logic              sm_q;

  // Conversion working set
  logic [WIDTH-1:0]  mag_q;
  logic [BW-1:0]     dig_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              neg_q;
  logic              zero_q;
  logic              ovf_q;

  // Handshake and held result
  logic              busy_q;
  logic              done_q;
  logic              valid_q;
  logic [BW-1:0]     bcd_q;
  logic              sign_q;
  logic [LD_W-1:0]   lead_q;
  logic              ovf_out_q;

  // Combinational helpers
  logic [BW-1:0]     adj;
  logic [BW-1:0]     dig_d;
  logic              carry_out;
  logic              neg_d;
  logic [WIDTH-1:0]  mag_d;
  logic [LD_W-1:0]   lead_d;

  // Next-state selection for the conversion sequencer
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_LOAD;
      S_LOAD:  state_d = S_SHIFT;
      S_SHIFT: if (cnt_q == CNT_W'(1)) state_d = S_DONE;
      S_DONE:  state_d = bus.start ? S_LOAD : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // One double-dabble step: add 3 to every digit >= 5, then shift the chain left by one bit
  always_comb begin
    adj = dig_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (dig_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = dig_q[4*k +: 4] + 4'd3;
    end
    dig_d     = {adj[BW-2:0], mag_q[WIDTH-1]};
    carry_out = adj[BW-1];
  end

  // Sign and magnitude of the captured operand; most-negative maps to 2^(WIDTH-1)
  always_comb begin
    neg_d = sm_q & a_q[WIDTH-1];
    mag_d = neg_d ? (~a_q + WIDTH'(1)) : a_q;
  end

  // Highest nonzero digit position plus one; an all-zero result still shows one digit
  always_comb begin
    lead_d = LD_W'(1);
    for (int k = 0; k < DIGITS; k++) begin
      if (dig_q[4*k +: 4] != 4'd0) lead_d = LD_W'(k + 1);
    end
  end

  // State register; reset aborts any conversion in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q       <= '0;
      sm_q      <= 1'b0;
      mag_q     <= '0;
      dig_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      bcd_q     <= '0;
      sign_q    <= 1'b0;
      lead_q    <= LD_W'(1);
      ovf_out_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          // Publishing happens while leaving DONE so the result and the next start share an edge
          if (state_q == S_DONE) begin
            bcd_q     <= dig_q;
            ovf_out_q <= ovf_q;
            sign_q    <= neg_q & ~zero_q;
            lead_q    <= lead_d;
            done_q    <= 1'b1;
            valid_q   <= 1'b1;
          end
          if (bus.start) begin
            a_q    <= bus.A;
            sm_q   <= bus.signed_mode;
            busy_q <= 1'b1;
          end
        end
        S_LOAD: begin
          neg_q   <= neg_d;
          mag_q   <= mag_d;
          zero_q  <= (a_q == '0);
          dig_q   <= '0;
          ovf_q   <= 1'b0;
          cnt_q   <= CNT_W'(WIDTH);
          valid_q <= 1'b0;
        end
        S_SHIFT: begin
          dig_q <= dig_d;
          mag_q <= {mag_q[WIDTH-2:0], 1'b0};
          cnt_q <= cnt_q - CNT_W'(1);
          if (carry_out) ovf_q <= 1'b1;
          if (cnt_q == CNT_W'(1)) busy_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.valid       = valid_q;
  assign bus.bcd         = bcd_q;
  assign bus.sign        = sign_q;
  assign bus.lead_digits = lead_q;
  assign bus.overflow    = ovf_out_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - directed self-checking bench for bin2bcd_seq (5-digit and 4-digit builds)
module tb_bin2bcd_seq;
  logic        clk;
  logic        reset;
  logic        start_r;
  logic        sm_r;
  logic [15:0] a_r;
  int          checks;
  int          errors;

  bin2bcd_seq_if #(.WIDTH(16), .DIGITS(5)) if5 ();
  bin2bcd_seq_if #(.WIDTH(16), .DIGITS(4)) if4 ();

  assign if5.start       = start_r;
  assign if5.signed_mode = sm_r;
  assign if5.A           = a_r;
  assign if4.start       = start_r;
  assign if4.signed_mode = sm_r;
  assign if4.A           = a_r;

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) u_dut5 (.clk(clk), .reset(reset), .bus(if5));
  bin2bcd_seq #(.WIDTH(16), .DIGITS(4)) u_dut4 (.clk(clk), .reset(reset), .bus(if4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Start one conversion; lat = edges after the accepting edge until done (-1 on timeout)
  task automatic run(input logic sm, input logic [15:0] a, output int lat, output int busy_n);
    lat    = -1;
    busy_n = 0;
    @(negedge clk);
    start_r = 1'b1;
    sm_r    = sm;
    a_r     = a;
    @(posedge clk);
    #1;
    if (if5.busy) busy_n++;
    @(negedge clk);
    start_r = 1'b0;
    a_r     = 16'h5A5A;
    sm_r    = ~sm;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (if5.done) begin
        lat = c;
        break;
      end
      if (if5.busy) busy_n++;
    end
  endtask

  task automatic test_reset();
    checks++;
    if (if5.busy !== 1'b0 || if5.done !== 1'b0 || if5.valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got busy=%b done=%b valid=%b exp 0 0 0", if5.busy, if5.done, if5.valid);
    end
    checks++;
    if (if5.bcd !== 20'h0 || if5.sign !== 1'b0 || if5.overflow !== 1'b0 || if5.lead_digits !== 3'd1) begin
      errors++;
      $display("FAIL reset_result got bcd=%h sign=%b ovf=%b lead=%0d exp 00000 0 0 1",
               if5.bcd, if5.sign, if5.overflow, if5.lead_digits);
    end
  endtask

  task automatic test_unsigned_max();
    int lat, bn;
    run(1'b0, 16'hFFFF, lat, bn);
    checks++;
    if (lat !== 18) begin errors++; $display("FAIL max_latency got %0d exp 18", lat); end
    checks++;
    if (bn !== 17) begin errors++; $display("FAIL max_busy_cycles got %0d exp 17", bn); end
    checks++;
    if (if5.bcd !== 20'h65535 || if5.sign !== 1'b0 || if5.lead_digits !== 3'd5 || if5.overflow !== 1'b0 || if5.valid !== 1'b1) begin
      errors++;
      $display("FAIL max_result got bcd=%h sign=%b lead=%0d ovf=%b valid=%b exp 65535 0 5 0 1",
               if5.bcd, if5.sign, if5.lead_digits, if5.overflow, if5.valid);
    end
    checks++;
    if (if4.bcd !== 16'h5535 || if4.overflow !== 1'b1) begin
      errors++;
      $display("FAIL d4_overflow got bcd=%h ovf=%b exp 5535 1", if4.bcd, if4.overflow);
    end
    @(posedge clk);
    #1;
    checks++;
    if (if5.done !== 1'b0 || if5.valid !== 1'b1 || if5.bcd !== 20'h65535) begin
      errors++;
      $display("FAIL done_pulse_hold got done=%b valid=%b bcd=%h exp 0 1 65535", if5.done, if5.valid, if5.bcd);
    end
  endtask

  task automatic test_signed();
    int lat, bn;
    run(1'b1, 16'hFFFF, lat, bn);
    checks++;
    if (lat !== 18 || if5.bcd !== 20'h00001 || if5.sign !== 1'b1 || if5.lead_digits !== 3'd1) begin
      errors++;
      $display("FAIL signed_m1 got lat=%0d bcd=%h sign=%b lead=%0d exp 18 00001 1 1",
               lat, if5.bcd, if5.sign, if5.lead_digits);
    end
    run(1'b1, 16'h8000, lat, bn);
    checks++;
    if (if5.bcd !== 20'h32768 || if5.sign !== 1'b1 || if5.lead_digits !== 3'd5 || if5.overflow !== 1'b0) begin
      errors++;
      $display("FAIL signed_min got bcd=%h sign=%b lead=%0d ovf=%b exp 32768 1 5 0",
               if5.bcd, if5.sign, if5.lead_digits, if5.overflow);
    end
    run(1'b1, 16'h0000, lat, bn);
    checks++;
    if (if5.bcd !== 20'h0 || if5.sign !== 1'b0 || if5.lead_digits !== 3'd1) begin
      errors++;
      $display("FAIL signed_zero got bcd=%h sign=%b lead=%0d exp 00000 0 1", if5.bcd, if5.sign, if5.lead_digits);
    end
  endtask

  task automatic test_lead_digits();
    int lat, bn;
    run(1'b0, 16'd907, lat, bn);
    checks++;
    if (if5.bcd !== 20'h00907 || if5.lead_digits !== 3'd3 || if5.sign !== 1'b0) begin
      errors++;
      $display("FAIL u907 got bcd=%h lead=%0d sign=%b exp 00907 3 0", if5.bcd, if5.lead_digits, if5.sign);
    end
    run(1'b0, 16'd9999, lat, bn);
    checks++;
    if (if4.bcd !== 16'h9999 || if4.overflow !== 1'b0 || if4.lead_digits !== 3'd4) begin
      errors++;
      $display("FAIL d4_9999 got bcd=%h ovf=%b lead=%0d exp 9999 0 4", if4.bcd, if4.overflow, if4.lead_digits);
    end
    checks++;
    if (if5.bcd !== 20'h09999 || if5.lead_digits !== 3'd4) begin
      errors++;
      $display("FAIL d5_9999 got bcd=%h lead=%0d exp 09999 4", if5.bcd, if5.lead_digits);
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    int extra;
    lat   = -1;
    extra = 0;
    @(negedge clk);
    start_r = 1'b1;
    sm_r    = 1'b0;
    a_r     = 16'd1000;
    @(posedge clk);
    @(negedge clk);
    start_r = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (c == 5) begin
        start_r = 1'b1;
        sm_r    = 1'b1;
        a_r     = 16'hF000;
      end
      if (c == 6) start_r = 1'b0;
      if (if5.done) begin
        lat = c;
        break;
      end
    end
    checks++;
    if (lat !== 18 || if5.bcd !== 20'h01000 || if5.sign !== 1'b0) begin
      errors++;
      $display("FAIL start_ignored got lat=%0d bcd=%h sign=%b exp 18 01000 0", lat, if5.bcd, if5.sign);
    end
    for (int c = 0; c < 24; c++) begin
      @(posedge clk);
      #1;
      if (if5.done || if5.busy) extra++;
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL no_stray_conv got %0d active cycles exp 0", extra); end
  endtask

  task automatic test_back_to_back();
    int n_done;
    int pos[3];
    int bad_val;
    n_done  = 0;
    bad_val = 0;
    pos     = '{-1, -1, -1};
    @(negedge clk);
    start_r = 1'b1;
    sm_r    = 1'b0;
    a_r     = 16'd12345;
    @(posedge clk);
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #1;
      if (c == 40) start_r = 1'b0;
      if (if5.done) begin
        if (n_done < 3) pos[n_done] = c;
        n_done++;
        if (if5.bcd !== 20'h12345) bad_val++;
      end
    end
    checks++;
    if (n_done !== 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", n_done); end
    checks++;
    if (pos[0] !== 18 || pos[1] !== 36 || pos[2] !== 54) begin
      errors++;
      $display("FAIL b2b_spacing got %0d %0d %0d exp 18 36 54", pos[0], pos[1], pos[2]);
    end
    checks++;
    if (bad_val !== 0) begin errors++; $display("FAIL b2b_value got %0d bad results exp 0", bad_val); end
  endtask

  task automatic test_reset_abort();
    int strays;
    strays = 0;
    @(negedge clk);
    start_r = 1'b1;
    sm_r    = 1'b0;
    a_r     = 16'd500;
    @(posedge clk);
    @(negedge clk);
    start_r = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (if5.busy !== 1'b1 || if5.valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_conv got busy=%b valid=%b exp 1 0", if5.busy, if5.valid);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (if5.busy !== 1'b0 || if5.valid !== 1'b0 || if5.done !== 1'b0 || if5.bcd !== 20'h0 || if5.lead_digits !== 3'd1) begin
      errors++;
      $display("FAIL async_abort got busy=%b valid=%b done=%b bcd=%h lead=%0d exp 0 0 0 00000 1",
               if5.busy, if5.valid, if5.done, if5.bcd, if5.lead_digits);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (if5.done || if5.busy || if5.valid) strays++;
    end
    checks++;
    if (strays !== 0) begin errors++; $display("FAIL after_abort got %0d active cycles exp 0", strays); end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b0;
    start_r = 1'b0;
    sm_r    = 1'b0;
    a_r     = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    reset = 1'b1;
    test_unsigned_max();
    test_signed();
    test_lead_digits();
    test_start_ignored();
    test_back_to_back();
    repeat (4) @(posedge clk);
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
